// File: rtl/serial_slice_subtractor_if.sv
// Operand/result handshake bundle for serial_slice_subtractor.
// master = producer/consumer side, slave = the subtractor.
interface serial_slice_subtractor_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/serial_slice_subtractor.sv
// Ripple-borrow subtractor, one SLICE-bit slice per clock, LSB slice first.
// Define SERIAL_SUB_SAT_EN to clamp a negative result to zero (bout unchanged).
module serial_slice_subtractor #(
    parameter int WIDTH = 12,
    parameter int SLICE = 3
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_slice_subtractor_if.slave s
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic [SLICE:0]   t;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] diff_fin;

    // One extra bit on the slice difference: its MSB is the outgoing borrow.
    always_comb begin
        t        = {1'b0, a_sh[SLICE-1:0]} - {1'b0, b_sh[SLICE-1:0]} - {{SLICE{1'b0}}, borrow};
        res_nxt  = {t[SLICE-1:0], res[WIDTH-1:SLICE]};
`ifdef SERIAL_SUB_SAT_EN
        diff_fin = t[SLICE] ? '0 : res_nxt;
`else
        diff_fin = res_nxt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            res         <= '0;
            borrow      <= 1'b0;
            cnt         <= '0;
            s.in_ready  <= 1'b1;
            s.out_valid <= 1'b0;
            s.diff      <= '0;
            s.bout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s.in_valid && s.in_ready) begin
                        a_sh       <= s.a;
                        b_sh       <= s.b;
                        borrow     <= s.bin;
                        cnt        <= '0;
                        s.in_ready <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> SLICE;
                    b_sh   <= b_sh >> SLICE;
                    res    <= res_nxt;
                    borrow <= t[SLICE];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(NSLICE - 1)) begin
                        s.diff      <= diff_fin;
                        s.bout      <= t[SLICE];
                        s.out_valid <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (s.out_ready) begin
                        s.out_valid <= 1'b0;
                        s.in_ready  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    s.in_ready  <= 1'b1;
                    s.out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_slice_subtractor.sv
// Self-checking bench: directed corner cases plus a random stream against an arithmetic model.
module tb_serial_slice_subtractor;
    localparam int W = 12;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    serial_slice_subtractor_if #(.WIDTH(W)) bus ();

    serial_slice_subtractor #(.WIDTH(W), .SLICE(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction, bout from the sign.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        int   d;
        logic bo;
        logic [W-1:0] r;
        d  = int'(ma) - int'(mb) - int'(mbin);
        bo = (d < 0);
        r  = W'(d & ((1 << W) - 1));
`ifdef SERIAL_SUB_SAT_EN
        if (bo) r = '0;
`endif
        return {bo, r};
    endfunction

    // Directed op: waits for in_ready, accepts, checks latency and result,
    // holds out_ready low for `hold` cycles (optionally poking in_valid), then drains.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                          input logic tbin, input int hold, input logic poke);
        logic [W:0] e;
        int n;
        e = model(ta, tb_b, tbin);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.a = ta; bus.b = tb_b; bus.bin = tbin; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
        n = 0;
        while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_lat"}, 32'(n), 32'd4);
        chk({tag, "_diff"}, 32'(bus.diff), 32'(e[W-1:0]));
        chk({tag, "_bout"}, 32'(bus.bout), 32'(e[W]));
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.in_valid = 1'b1; bus.a = 12'hABC; bus.b = 12'h001; bus.bin = 1'b0;
            end
            @(posedge clk); #1;
            chk({tag, "_hold_v"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_d"}, 32'(bus.diff), 32'(e[W-1:0]));
            chk({tag, "_hold_b"}, 32'(bus.bout), 32'(e[W]));
            chk({tag, "_hold_r"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_drain_v"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_drain_r"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_keep_d"}, 32'(bus.diff), 32'(e[W-1:0]));
        if (poke) begin
            // a leaked capture would have started a RUN instead of sitting idle
            @(posedge clk); #1;
            chk({tag, "_nocap"}, 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [W:0]   e;
        logic [W*2:0] q[$];
        logic [W*2:0] ent;
        int last_acc, n_acc, n_res, cyc;

        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy",  32'(bus.in_ready),  32'd1);
        chk("rst_vld",  32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff),      32'd0);
        chk("rst_bout", 32'(bus.bout),      32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("t1",   12'h123, 12'h023, 1'b0, 0, 1'b0);
        run_op("t2",   12'h000, 12'h001, 1'b0, 0, 1'b0);
        run_op("t3a",  12'h555, 12'h555, 1'b1, 0, 1'b0);
        run_op("t3b",  12'h555, 12'h555, 1'b0, 0, 1'b0);
        run_op("t4",   12'h7A1, 12'h3B2, 1'b1, 5, 1'b1);

        // reset while in RUN with two slices done
        @(negedge clk);
        bus.a = 12'hFFF; bus.b = 12'h001; bus.bin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_vld",  32'(bus.out_valid), 32'd0);
        chk("t5_rdy",  32'(bus.in_ready),  32'd1);
        chk("t5_diff", 32'(bus.diff),      32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("t5_noout", 32'(bus.out_valid), 32'd0);
        end
        run_op("t5_next", 12'h800, 12'h001, 1'b0, 0, 1'b0);

        // random stream, out_ready tied high
        bus.out_ready = 1'b1;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
        bus.in_valid = 1'b1;
        last_acc = -1; n_acc = 0; n_res = 0; cyc = 0;
        while ((n_acc < 100 || n_res < 100) && cyc < 1000) begin
            logic acc;
            @(negedge clk);
            cyc++;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("t6_spurious", 32'd1, 32'd0);
                end else begin
                    ent = q.pop_front();
                    e = model(ent[W*2:W+1], ent[W:1], ent[0]);
                    chk("t6_diff", 32'(bus.diff), 32'(e[W-1:0]));
                    chk("t6_bout", 32'(bus.bout), 32'(e[W]));
                end
                n_res++;
            end
            if (acc) begin
                q.push_back({bus.a, bus.b, bus.bin});
                if (last_acc >= 0) chk("t6_space", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                n_acc++;
                @(posedge clk); #1;
                if (n_acc >= 100) bus.in_valid = 1'b0;
                bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
            end
        end
        chk("t6_nacc", 32'(n_acc), 32'd100);
        chk("t6_nres", 32'(n_res), 32'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
